// File: rtl/hs_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hs_ram_arbiter
// Purpose  : Hands the core work-RAM port to the hiscore engine while the CPU
//            is paused. Define HS_ARB_VBL_SYNC_EN to delay the handover until
//            vertical blank, with a timeout.
// Revision : 1.0 - initial release
// ============================================================================
module hs_ram_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 8,
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 2000000
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          user_pause,
    input  logic          vblank,
    input  logic          hs_req,
    input  logic [AW-1:0] hs_ad,
    input  logic [DW-1:0] hs_din,
    input  logic          hs_we,
    output logic          hs_grant,
    output logic [DW-1:0] hs_dout,
    input  logic [AW-1:0] cpu_ad,
    input  logic [DW-1:0] cpu_din,
    input  logic          cpu_we,
    output logic [AW-1:0] ram_ad,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout,
    output logic          pause_n,
    output logic [15:0]   wr_count
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_VBL = 3'd1,
        S_STALL    = 3'd2,
        S_GRANT    = 3'd3,
        S_RELEASE  = 3'd4
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t      r_state;
    logic        r_arb_pause;
    logic        r_grant;
    logic [3:0]  r_settle;
    logic [15:0] r_wr_count;

`ifdef HS_ARB_VBL_SYNC_EN
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] r_tmo;
    logic          w_vbl_go;

    assign w_vbl_go = vblank || (r_tmo == TMO_LAST);
`else
    logic w_unused_vblank;

    assign w_unused_vblank = vblank;
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_arb_pause <= 1'b0;
            r_grant     <= 1'b0;
            r_settle    <= 4'd0;
            r_wr_count  <= 16'd0;
`ifdef HS_ARB_VBL_SYNC_EN
            r_tmo       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (hs_req) begin
                        r_state <= S_WAIT_VBL;
`ifdef HS_ARB_VBL_SYNC_EN
                        r_tmo   <= '0;
`endif
                    end
                end
                S_WAIT_VBL: begin
`ifdef HS_ARB_VBL_SYNC_EN
                    if (!hs_req) begin
                        r_state <= S_IDLE;
                    end else if (w_vbl_go) begin
                        r_state     <= S_STALL;
                        r_settle    <= SETTLE_LOAD;
                        r_arb_pause <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
`else
                    r_state     <= S_STALL;
                    r_settle    <= SETTLE_LOAD;
                    r_arb_pause <= 1'b1;
`endif
                end
                S_STALL: begin
                    // A withdrawn request still goes through RELEASE so the
                    // CPU bus is held quiet for one more cycle before un-pausing.
                    if (!hs_req) begin
                        r_state <= S_RELEASE;
                    end else if (r_settle == 4'd0) begin
                        r_state <= S_GRANT;
                        r_grant <= 1'b1;
                    end else begin
                        r_settle <= r_settle - 1'b1;
                    end
                end
                S_GRANT: begin
                    if (hs_we && (r_wr_count != 16'hFFFF)) begin
                        r_wr_count <= r_wr_count + 16'd1;
                    end
                    if (!hs_req) begin
                        r_state <= S_RELEASE;
                        r_grant <= 1'b0;
                    end
                end
                S_RELEASE: begin
                    r_state     <= S_IDLE;
                    r_arb_pause <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_arb_pause <= 1'b0;
                    r_grant     <= 1'b0;
                end
            endcase
        end
    end

    // Mux driven from the registered grant so the select never glitches.
    assign hs_grant = r_grant;
    assign hs_dout  = ram_dout;
    assign ram_ad   = r_grant ? hs_ad  : cpu_ad;
    assign ram_din  = r_grant ? hs_din : cpu_din;
    assign ram_we   = r_grant ? hs_we  : (cpu_we & ~r_arb_pause);
    assign pause_n  = ~(user_pause | r_arb_pause);
    assign wr_count = r_wr_count;

endmodule
`default_nettype wire
